// File: rtl/status_flag_unit_pkg.sv
// Shared constants for the status flag producer: ALU command codes and
// status bit positions within the packed {z,c,n,v} bus.
package status_flag_unit_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } alu_cmd_e;

  // Compare/test share encodings with their data-processing counterparts.
  localparam alu_cmd_e CMD_CMP = CMD_SUB;
  localparam alu_cmd_e CMD_TST = CMD_AND;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE/ID-side bundle between the pipeline and the status flag unit.
interface status_flag_unit_if;

  logic        id_issue_s;
  logic        stall;
  logic        exe_valid;
  logic        exe_s;
  logic        exe_cond_pass;
  logic        exe_flush;
  logic [3:0]  exe_cmd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        shifter_carry;
  logic [3:0]  status;
  logic [3:0]  status_fwd;
  logic        flags_pending;
  logic        issue_ready;
  logic        cnt_err;

  modport master (
    output id_issue_s, stall, exe_valid, exe_s, exe_cond_pass, exe_flush,
           exe_cmd, op_a, op_b, alu_result, shifter_carry,
    input  status, status_fwd, flags_pending, issue_ready, cnt_err
  );

  modport slave (
    input  id_issue_s, stall, exe_valid, exe_s, exe_cond_pass, exe_flush,
           exe_cmd, op_a, op_b, alu_result, shifter_carry,
    output status, status_fwd, flags_pending, issue_ready, cnt_err
  );

endinterface

// File: rtl/status_flag_unit_flag_calc.sv
// Combinational next-flag computation from the EXE-stage ALU command,
// operands, result, shifter carry and the current status.
module status_flag_unit_flag_calc
  import status_flag_unit_pkg::*;
(
  input  logic [3:0]  cmd_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] result_i,
  input  logic        shifter_carry_i,
  input  logic [3:0]  old_i,
  output logic [3:0]  flags_o
);

  logic [32:0] wide;
  logic        extra;

  always_comb begin
    flags_o         = old_i;
    wide            = '0;
    extra           = 1'b0;
    flags_o[FLAG_N] = result_i[31];
    flags_o[FLAG_Z] = (result_i == '0);
    case (alu_cmd_e'(cmd_i))
      CMD_ADD, CMD_ADC: begin
        extra           = (cmd_i == CMD_ADC) ? old_i[FLAG_C] : 1'b0;
        wide            = {1'b0, op_a_i} + {1'b0, op_b_i} + {32'd0, extra};
        flags_o[FLAG_C] = wide[32];
        flags_o[FLAG_V] = (op_a_i[31] == op_b_i[31]) && (result_i[31] != op_a_i[31]);
      end
      CMD_SUB, CMD_SBC: begin
        // Bit 32 of the 33-bit difference is the borrow; C is its inverse.
        extra           = (cmd_i == CMD_SBC) ? ~old_i[FLAG_C] : 1'b0;
        wide            = {1'b0, op_a_i} - {1'b0, op_b_i} - {32'd0, extra};
        flags_o[FLAG_C] = ~wide[32];
        flags_o[FLAG_V] = (op_a_i[31] != op_b_i[31]) && (result_i[31] != op_a_i[31]);
      end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        flags_o[FLAG_C] = shifter_carry_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural status register with same-cycle bypass, plus the in-flight
// tracker for flag-setting instructions used by the ID-stage hazard logic.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic           clk,
  input  logic           rst,
  status_flag_unit_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [3:0]       status_q, status_d;
  logic [3:0]       new_flags;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             commit, inc, dec, ready;

  status_flag_unit_flag_calc u_flag_calc (
    .cmd_i           (bus.exe_cmd),
    .op_a_i          (bus.op_a),
    .op_b_i          (bus.op_b),
    .result_i        (bus.alu_result),
    .shifter_carry_i (bus.shifter_carry),
    .old_i           (status_q),
    .flags_o         (new_flags)
  );

  always_comb begin
    commit = bus.exe_valid & bus.exe_s & bus.exe_cond_pass & ~bus.exe_flush & ~bus.stall;
    ready  = (cnt_q < CNT_MAX);
    inc    = bus.id_issue_s & ~bus.stall & ready;
    // Retire counts every S-bit instruction leaving EXE, squashed or not.
    dec    = bus.exe_valid & bus.exe_s & ~bus.stall;

    status_d = commit ? new_flags : status_q;

    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    err_d = err_q
          | (bus.id_issue_s & ~bus.stall & ~ready)
          | (dec & ~inc & (cnt_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.status        = status_q;
  assign bus.status_fwd    = status_d;
  assign bus.flags_pending = (cnt_q != '0);
  assign bus.issue_ready   = ready;
  assign bus.cnt_err       = err_q;

endmodule
